wb_arbiter_3: RTL and testbench
===============================

Name: wb_arbiter_3

Overview:
- Clocked write-back arbiter for the three execution units fed by the opcode-steered request split:
  - unit 0: branch/jump
  - unit 1: load/store
  - unit 2: ALU/NOP
- Each unit finishes with a four-phase req/ack handshake carrying bundled write-back data.
- The arbiter serialises these onto the single register-file write port using round-robin priority, then returns ack to the winner.
- It also produces the completion acks that the split's ack join consumes.

Parameters:
DATA_W, 32, register write data width
ADDR_W, 5, register index width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
req_i  in  3  four-phase request per unit; bit index = unit index
we_i  in  3  unit i requests a register write (0 for B/S-type); bundled with req_i[i]
waddr_i  in  3*ADDR_W  destination index; slice i belongs to unit i
wdata_i  in  3*DATA_W  write data; slice i belongs to unit i
ack_o  out  3  four-phase acknowledge per unit
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  ADDR_W  register-file write index
rf_wdata_o  out  DATA_W  register-file write data
busy_o  out  1  arbiter not in IDLE

Behaviour:
- Interface fact: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0, gnt=0
  - ack_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, busy_o=0
- req_s is the request vector as seen by the FSM:
  - SYNC macro on: synchronised req_i.
  - SYNC macro off: req_i directly.
- Bundled-data rule: we_i/waddr_i/wdata_i slice i is stable from before req_i[i] rises until after ack_o[i] rises.
- FSM states: IDLE, WRITE, ACK_HI.
- IDLE:
  - If req_s != 0, choose gnt as the first set bit scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - Register rf_waddr_o and rf_wdata_o from slice gnt.
  - Register rf_we_o = we_i[gnt] && (waddr_i[gnt] != 0). Writes to x0 are suppressed, but the handshake still completes.
  - Go to WRITE.
- WRITE (exactly one cycle):
  - rf_we_o <= 0; ack_o[gnt] <= 1.
  - rr_ptr <= (gnt==2) ? 0 : gnt+1.
  - Go to ACK_HI.
- ACK_HI:
  - Hold ack_o[gnt] = 1 until req_s[gnt] == 0.
  - Then ack_o[gnt] <= 0 and go to IDLE; a new grant is possible on the following edge.
- Other outputs:
  - rf_waddr_o/rf_wdata_o hold their last value outside WRITE.
  - busy_o = (state != IDLE), registered with state.
- Latency, SYNC off (E1 = first edge where req_i[i] is high in IDLE):
  - rf_we_o is high for the single cycle E1..E2.
  - ack_o[i] rises after E2.
  - ack_o[i] falls one edge after req_i[i] is seen low.
- Latency, SYNC on: every req-related figure above is delayed by 2 cycles.
- Simultaneous requests: exactly one grant per transaction; losers keep req high and are served in later transactions in round-robin order. No starvation: each pending unit is served within 3 transactions.
- Request arriving during WRITE/ACK_HI: ignored until IDLE.
- Protocol violations:
  - req_s[gnt] falling during WRITE is ignored and the transaction completes.
  - Non-granted ack bits stay 0 at all times.
  - ack_o is one-hot or zero.
- Reset mid-transaction: all outputs are forced to reset values immediately. A unit still holding req is re-served after reset; re-writing the same data is idempotent.

Optional Feature:
- Macro: WB_ARB_SYNC_EN.
- Defined: each req_i bit passes through a 2-flop synchroniser (reset to 0) before the FSM. This is required when units are self-timed, and adds 2 cycles of request latency.
- Undefined: req_i feeds the FSM directly; requesters must be synchronous to clk. All other behaviour is identical.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, WRITE, ACK_HI}
  - NREQ=3
  - unit index constants UNIT_BJ=0, UNIT_LS=1, UNIT_ALU=2, matching the split's control-bit order
  - round-robin next-pointer function
- Sub-module sync_2ff: 1-bit, async active-low reset. Instantiated ×3 only under WB_ARB_SYNC_EN.

Test Plan:
- SYNC off. Single write: req_i=3'b100, we_i[2]=1, waddr=5'd7, wdata=32'hDEADBEEF.
  - Expect rf_we_o=1 for one cycle after E1 with addr 7 and data DEADBEEF.
  - Expect ack_o=3'b100 after E2; ack_o cleared one edge after req_i[2] drops.
- x0 and no-write: waddr=0, we=1 -> rf_we_o stays 0 while ack_o completes normally. Repeat with we_i=0, waddr=5 -> same result.
- Contention: req_i=3'b111 held continuously with four-phase cycling, rr_ptr=0 -> grant order 0,1,2,0,1,2. rf_waddr_o matches each slice.
- Late arrival: req_i[0] rises during ACK_HI of unit 1 -> unit 0 is not granted until IDLE. Next grant is unit 2 if pending, else unit 0.
- Reset mid-transaction: assert rst_n=0 in ACK_HI -> ack_o=0, rf_we_o=0, busy_o=0 immediately. After release with req still high, the transaction replays with identical data.
- WB_ARB_SYNC_EN defined: repeat the single-write test -> rf_we_o after E3 and ack_o after E4. Glitch-free ack_o, one-hot or zero, is checked by assertion throughout.

Source files
------------

// File: rtl/wb_arbiter_3_pkg.sv
// Shared types and helpers for the three-unit write-back arbiter.
// Used by wb_arbiter_3; the optional WB_ARB_SYNC_EN build needs nothing extra from here.
package wb_arb_pkg;

   localparam int NREQ     = 3;
   localparam int UNIT_BJ  = 0;
   localparam int UNIT_LS  = 1;
   localparam int UNIT_ALU = 2;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      ACK_HI
   } arbState_t;

   function automatic logic [1:0] rrNext(input logic [1:0] gnt);
      return (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
   endfunction

   // First requesting unit scanning ptr, ptr+1, ptr+2 (mod 3).
   function automatic logic [1:0] rrPick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      rrPick = ptr;
      idx    = ptr;
      found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[idx]) begin
            rrPick = idx;
            found  = 1'b1;
         end
         idx = rrNext(idx);
      end
   endfunction

endpackage

// File: rtl/wb_arbiter_3_sync_2ff.sv
// Two-flop synchroniser for one request bit; instantiated by wb_arbiter_3 only
// when WB_ARB_SYNC_EN is defined.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/wb_arbiter_3.sv
// Round-robin arbiter serialising three four-phase write-back handshakes onto one
// register-file write port. Define WB_ARB_SYNC_EN to synchronise req_i (+2 cycles).
module wb_arbiter_3
   import wb_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_i,
   input  logic [NREQ-1:0]          we_i,
   input  logic [NREQ*ADDR_W-1:0]   waddr_i,
   input  logic [NREQ*DATA_W-1:0]   wdata_i,
   output logic [NREQ-1:0]          ack_o,
   output logic                     rf_we_o,
   output logic [ADDR_W-1:0]        rf_waddr_o,
   output logic [DATA_W-1:0]        rf_wdata_o,
   output logic                     busy_o
);

   logic [NREQ-1:0] w_reqS;

`ifdef WB_ARB_SYNC_EN
   for (genvar g = 0; g < NREQ; g++) begin : gSync
      sync_2ff u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .i_d   (req_i[g]),
         .o_q   (w_reqS[g])
      );
   end
`else
   assign w_reqS = req_i;
`endif

   logic [ADDR_W-1:0] w_addrArr [NREQ];
   logic [DATA_W-1:0] w_dataArr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : gSlice
      assign w_addrArr[g] = waddr_i[g*ADDR_W +: ADDR_W];
      assign w_dataArr[g] = wdata_i[g*DATA_W +: DATA_W];
   end

   arbState_t         r_state;
   arbState_t         w_stateNext;
   logic [1:0]        r_rrPtr;
   logic [1:0]        r_gnt;
   logic [NREQ-1:0]   r_ack;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_busy;

   logic [1:0]        w_pick;
   logic [1:0]        w_rrPtrNext;
   logic [1:0]        w_gntNext;
   logic [NREQ-1:0]   w_ackNext;
   logic              w_weNext;
   logic [ADDR_W-1:0] w_waddrNext;
   logic [DATA_W-1:0] w_wdataNext;

   assign w_pick = rrPick(w_reqS, r_rrPtr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_reqS != '0) w_stateNext = WRITE;
         WRITE:   w_stateNext = ACK_HI;
         ACK_HI:  if (!w_reqS[r_gnt]) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Writes to x0 are dropped, but the winner's handshake still runs to completion.
   always_comb begin
      w_rrPtrNext = r_rrPtr;
      w_gntNext   = r_gnt;
      w_ackNext   = r_ack;
      w_weNext    = r_we;
      w_waddrNext = r_waddr;
      w_wdataNext = r_wdata;
      case (r_state)
         IDLE: begin
            if (w_reqS != '0) begin
               w_gntNext   = w_pick;
               w_waddrNext = w_addrArr[w_pick];
               w_wdataNext = w_dataArr[w_pick];
               w_weNext    = we_i[w_pick] && (w_addrArr[w_pick] != '0);
            end
         end
         WRITE: begin
            w_weNext    = 1'b0;
            w_ackNext   = NREQ'(1) << r_gnt;
            w_rrPtrNext = rrNext(r_gnt);
         end
         ACK_HI: begin
            if (!w_reqS[r_gnt]) w_ackNext = '0;
         end
         default: begin
            w_ackNext = '0;
            w_weNext  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rrPtr <= 2'd0;
         r_gnt   <= 2'd0;
         r_ack   <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_rrPtr <= w_rrPtrNext;
         r_gnt   <= w_gntNext;
         r_ack   <= w_ackNext;
         r_we    <= w_weNext;
         r_waddr <= w_waddrNext;
         r_wdata <= w_wdataNext;
         r_busy  <= (w_stateNext != IDLE);
      end
   end

   assign ack_o      = r_ack;
   assign rf_we_o    = r_we;
   assign rf_waddr_o = r_waddr;
   assign rf_wdata_o = r_wdata;
   assign busy_o     = r_busy;

endmodule

// File: tb/tb_wb_arbiter_3.sv
// Directed bench for wb_arbiter_3 with a scoreboard of expected write-backs.
// Request latency adapts when WB_ARB_SYNC_EN is defined.
module tb_wb_arbiter_3;
   import wb_arb_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
`ifdef WB_ARB_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [NREQ-1:0]        req_i;
   logic [NREQ-1:0]        we_i;
   logic [NREQ*ADDR_W-1:0] waddr_i;
   logic [NREQ*DATA_W-1:0] wdata_i;
   logic [NREQ-1:0]        ack_o;
   logic                   rf_we_o;
   logic [ADDR_W-1:0]      rf_waddr_o;
   logic [DATA_W-1:0]      rf_wdata_o;
   logic                   busy_o;

   wb_arbiter_3 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .we_i       (we_i),
      .waddr_i    (waddr_i),
      .wdata_i    (wdata_i),
      .ack_o      (ack_o),
      .rf_we_o    (rf_we_o),
      .rf_waddr_o (rf_waddr_o),
      .rf_wdata_o (rf_wdata_o),
      .busy_o     (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                unit;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sbq[$];
   exp_t monE;
   int   nAssert = 0;
   int   nFail   = 0;
   int   u;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] oneHot(input int k);
      logic [NREQ-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic setUnit(input int k, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      we_i[k]                   = we;
      waddr_i[k*ADDR_W +: ADDR_W] = a;
      wdata_i[k*DATA_W +: DATA_W] = d;
   endtask

   task automatic pushExp(input int k, input logic expWe);
      exp_t e;
      e.unit = k;
      e.we   = expWe;
      e.addr = waddr_i[k*ADDR_W +: ADDR_W];
      e.data = wdata_i[k*DATA_W +: DATA_W];
      sbq.push_back(e);
   endtask

   task automatic applyStimulus(input int k);
      req_i[k] = 1'b1;
   endtask

   task automatic waitAckHigh(output int k);
      int n = 0;
      while (ack_o == '0 && n < 40) begin
         tick();
         n++;
      end
      checkOutput("ackRise", ack_o != '0, 1);
      k = ack_o[0] ? 0 : (ack_o[1] ? 1 : 2);
   endtask

   task automatic releaseUnit(input int k);
      int n = 0;
      req_i[k] = 1'b0;
      while (ack_o != '0 && n < 40) begin
         tick();
         n++;
      end
      checkOutput("ackFall", ack_o == '0, 1);
   endtask

   task automatic doReset();
      req_i = '0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Every ack rising edge retires the oldest expected write-back.
   logic [NREQ-1:0] prevAck = '0;
   logic            prevWe  = 1'b0;

   always @(negedge clk) begin
      nAssert++;
      assert ($onehot0(ack_o)) else begin
         nFail++;
         $error("[TB] FAIL ackOneHot observed=%0b expected=onehot0", ack_o);
      end
      if (ack_o != '0 && prevAck == '0) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpectedAck", ack_o, 0);
         end else begin
            monE = sbq.pop_front();
            checkOutput("ackUnit", ack_o, oneHot(monE.unit));
            checkOutput("rfWe", prevWe, monE.we);
            checkOutput("rfAddr", rf_waddr_o, monE.addr);
            checkOutput("rfData", rf_wdata_o, monE.data);
         end
      end
      prevAck = ack_o;
      prevWe  = rf_we_o;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      req_i   = '0;
      we_i    = '0;
      waddr_i = '0;
      wdata_i = '0;
      rst_n   = 1'b0;
      repeat (2) tick();
      checkOutput("rstAck", ack_o, 0);
      checkOutput("rstWe", rf_we_o, 0);
      checkOutput("rstAddr", rf_waddr_o, 0);
      checkOutput("rstData", rf_wdata_o, 0);
      checkOutput("rstBusy", busy_o, 0);
      rst_n = 1'b1;
      tick();

      // Single write with cycle-exact latency.
      setUnit(UNIT_ALU, 1'b1, 5'd7, 32'hDEADBEEF);
      pushExp(UNIT_ALU, 1'b1);
      applyStimulus(UNIT_ALU);
      repeat (LAT) begin
         tick();
         checkOutput("weBeforeGrant", rf_we_o, 0);
      end
      tick();
      checkOutput("swWeHigh", rf_we_o, 1);
      checkOutput("swAddr", rf_waddr_o, 7);
      checkOutput("swData", rf_wdata_o, 32'hDEADBEEF);
      checkOutput("swBusy", busy_o, 1);
      checkOutput("swAckLow", ack_o, 0);
      tick();
      checkOutput("swWeLow", rf_we_o, 0);
      checkOutput("swAck", ack_o, 3'b100);
      req_i[UNIT_ALU] = 1'b0;
      repeat (LAT) begin
         tick();
         checkOutput("swAckHold", ack_o, 3'b100);
      end
      tick();
      checkOutput("swAckClr", ack_o, 0);
      checkOutput("swBusyClr", busy_o, 0);

      // Write to x0, then a no-write request: handshake only.
      setUnit(UNIT_LS, 1'b1, 5'd0, 32'h12345678);
      pushExp(UNIT_LS, 1'b0);
      applyStimulus(UNIT_LS);
      waitAckHigh(u);
      checkOutput("x0Unit", u, UNIT_LS);
      releaseUnit(u);
      setUnit(UNIT_LS, 1'b0, 5'd5, 32'h0BADF00D);
      pushExp(UNIT_LS, 1'b0);
      applyStimulus(UNIT_LS);
      waitAckHigh(u);
      checkOutput("noWrUnit", u, UNIT_LS);
      releaseUnit(u);

      // Contention from a fresh pointer: 0,1,2,0,1,2.
      doReset();
      for (int k = 0; k < NREQ; k++) setUnit(k, 1'b1, 5'(10 + k), 32'hC0DE0000 + k);
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < NREQ; k++) pushExp(k, 1'b1);
      req_i = 3'b111;
      for (int i = 0; i < 6; i++) begin
         waitAckHigh(u);
         checkOutput("rrOrder", u, i % 3);
         releaseUnit(u);
         if (i < 3) applyStimulus(u);
      end

      // Late arrivals during ACK_HI wait for IDLE; pointer then favours unit 2.
      setUnit(UNIT_LS, 1'b1, 5'd17, 32'h11111111);
      pushExp(UNIT_LS, 1'b1);
      applyStimulus(UNIT_LS);
      waitAckHigh(u);
      checkOutput("lateFirst", u, UNIT_LS);
      setUnit(UNIT_BJ, 1'b1, 5'd3, 32'h00000BB0);
      setUnit(UNIT_ALU, 1'b1, 5'd4, 32'h00000AA2);
      pushExp(UNIT_ALU, 1'b1);
      pushExp(UNIT_BJ, 1'b1);
      applyStimulus(UNIT_BJ);
      applyStimulus(UNIT_ALU);
      repeat (3 + LAT) begin
         tick();
         checkOutput("lateHold", ack_o, 3'b010);
      end
      releaseUnit(UNIT_LS);
      waitAckHigh(u);
      checkOutput("lateNext", u, UNIT_ALU);
      releaseUnit(u);
      waitAckHigh(u);
      checkOutput("lateLast", u, UNIT_BJ);
      releaseUnit(u);

      // Reset in ACK_HI, then replay with the same data.
      setUnit(UNIT_LS, 1'b1, 5'd9, 32'hA5A50009);
      pushExp(UNIT_LS, 1'b1);
      applyStimulus(UNIT_LS);
      waitAckHigh(u);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstAck", ack_o, 0);
      checkOutput("midRstWe", rf_we_o, 0);
      checkOutput("midRstBusy", busy_o, 0);
      checkOutput("midRstAddr", rf_waddr_o, 0);
      pushExp(UNIT_LS, 1'b1);
      tick();
      tick();
      rst_n = 1'b1;
      waitAckHigh(u);
      checkOutput("replayUnit", u, UNIT_LS);
      checkOutput("replayAddr", rf_waddr_o, 9);
      checkOutput("replayData", rf_wdata_o, 32'hA5A50009);
      releaseUnit(u);

      repeat (2) tick();
      checkOutput("sbEmpty", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
